// File: rtl/hms_clock_ctrl_if.sv
// rtl/hms_clock_ctrl_if.sv - button, counter and display signal bundle for hms_clock_ctrl
// Groups the front-panel, counter feedback and display-control signals of the clock controller.
interface hms_clock_ctrl_if;
  logic       i_sw0;
  logic       i_sw1;
  logic       i_sw2;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hour;
  logic       o_sec_inc;
  logic       o_min_inc;
  logic       o_hour_inc;
  logic [1:0] o_mode;
  logic [1:0] o_position;
  logic [5:0] o_alarm_min;
  logic [4:0] o_alarm_hour;
  logic       o_armed;
  logic       o_buzz;
  logic       o_disp_alarm;
  logic [2:0] o_blink;

  modport slave (
    input  i_sw0, i_sw1, i_sw2, i_sec, i_min, i_hour,
    output o_sec_inc, o_min_inc, o_hour_inc, o_mode, o_position,
           o_alarm_min, o_alarm_hour, o_armed, o_buzz, o_disp_alarm, o_blink
  );

  modport master (
    output i_sw0, i_sw1, i_sw2, i_sec, i_min, i_hour,
    input  o_sec_inc, o_min_inc, o_hour_inc, o_mode, o_position,
           o_alarm_min, o_alarm_hour, o_armed, o_buzz, o_disp_alarm, o_blink
  );
endinterface

// File: rtl/hms_clock_ctrl.sv
// rtl/hms_clock_ctrl.sv - mode/timekeeping controller for the hms digital clock
// Drives single-cycle count enables, debounces three buttons and runs the CLOCK/SETUP/ALARM machine.
module hms_clock_ctrl #(
  parameter int TICK_1HZ    = 50_000_000,
  parameter int TICK_SAMPLE = 500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  hms_clock_ctrl_if.slave    hms_if
);

  localparam int CW = $clog2(TICK_1HZ);
  localparam int SW = (TICK_SAMPLE > 1) ? $clog2(TICK_SAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_1HZ - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(TICK_1HZ / 2 - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(TICK_SAMPLE - 1);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0]    d1_q, d1_d;
  logic [2:0]    d2_q, d2_d;
  mode_e         mode_q, mode_d;
  pos_e          pos_q, pos_d;
  logic          sec_inc_q, sec_inc_d;
  logic          min_inc_q, min_inc_d;
  logic          hour_inc_q, hour_inc_d;
  logic [5:0]    alarm_min_q, alarm_min_d;
  logic [4:0]    alarm_hour_q, alarm_hour_d;
  logic          armed_q, armed_d;
  logic          buzz_q, buzz_d;
  logic          disp_alarm_q, disp_alarm_d;
  logic [2:0]    blink_q, blink_d;

  logic       tick;
  logic       stick;
  logic [2:0] raw;
  logic [2:0] press;
  logic       press_0, press_1, press_2;
  logic       is_setup, is_alarm, is_clock;

  assign tick  = (cnt_q == CNT_LAST);
  assign stick = (scnt_q == SCNT_LAST);
  assign raw   = {hms_if.i_sw2, hms_if.i_sw1, hms_if.i_sw0};

  // A press is a sampled high-to-low transition; higher-numbered buttons lose same-cycle ties.
  assign press   = {3{stick}} & d2_q & ~d1_q;
  assign press_0 = press[0];
  assign press_1 = press[1] & ~press[0];
  assign press_2 = press[2] & ~press[1] & ~press[0];

  assign is_setup = (mode_q == MODE_SETUP);
  assign is_alarm = (mode_q == MODE_ALARM);
  assign is_clock = ~is_setup & ~is_alarm;

  always_comb begin
    cnt_d        = (tick) ? '0 : cnt_q + 1'b1;
    phase_d      = (tick || cnt_q == CNT_HALF) ? ~phase_q : phase_q;
    scnt_d       = (stick) ? '0 : scnt_q + 1'b1;
    d1_d         = (stick) ? raw : d1_q;
    d2_d         = (stick) ? d1_q : d2_q;
    mode_d       = mode_q;
    pos_d        = pos_q;
    sec_inc_d    = 1'b0;
    min_inc_d    = 1'b0;
    hour_inc_d   = 1'b0;
    alarm_min_d  = alarm_min_q;
    alarm_hour_d = alarm_hour_q;
    armed_d      = armed_q;

    // Timekeeping is judged against the mode in force before any same-cycle mode change.
    if (is_setup) begin
      if (press_2) begin
        case (pos_q)
          POS_SEC:  sec_inc_d  = 1'b1;
          POS_MIN:  min_inc_d  = 1'b1;
          POS_HOUR: hour_inc_d = 1'b1;
          default:  ;
        endcase
      end
    end else begin
      sec_inc_d  = tick;
      min_inc_d  = tick && (hms_if.i_sec == 6'd59);
      hour_inc_d = tick && (hms_if.i_sec == 6'd59) && (hms_if.i_min == 6'd59);
    end

    if (press_0) begin
      case (mode_q)
        MODE_SETUP: begin
          mode_d = MODE_ALARM;
          pos_d  = POS_MIN;
        end
        MODE_ALARM: begin
          mode_d  = MODE_CLOCK;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
        default: begin
          mode_d = MODE_SETUP;
          pos_d  = POS_SEC;
        end
      endcase
    end else if (press_1) begin
      if (is_setup) begin
        case (pos_q)
          POS_SEC: pos_d = POS_MIN;
          POS_MIN: pos_d = POS_HOUR;
          default: pos_d = POS_SEC;
        endcase
      end else if (is_alarm) begin
        pos_d = (pos_q == POS_HOUR) ? POS_MIN : POS_HOUR;
      end
    end else if (press_2) begin
      if (is_alarm) begin
        if (pos_q == POS_HOUR) begin
          alarm_hour_d = (alarm_hour_q == 5'd23) ? 5'd0 : alarm_hour_q + 5'd1;
        end else begin
          alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
        end
      end else if (is_clock) begin
        armed_d = ~armed_q;
      end
    end

    buzz_d = armed_q && !is_setup &&
             (hms_if.i_hour == alarm_hour_q) && (hms_if.i_min == alarm_min_q);
    disp_alarm_d = is_alarm;

    blink_d = 3'b000;
    if (!is_clock) begin
      case (pos_q)
        POS_SEC:  blink_d[0] = phase_q;
        POS_MIN:  blink_d[1] = phase_q;
        POS_HOUR: blink_d[2] = phase_q;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      scnt_q       <= '0;
      d1_q         <= 3'b111;
      d2_q         <= 3'b111;
      mode_q       <= MODE_CLOCK;
      pos_q        <= POS_SEC;
      sec_inc_q    <= 1'b0;
      min_inc_q    <= 1'b0;
      hour_inc_q   <= 1'b0;
      alarm_min_q  <= 6'd0;
      alarm_hour_q <= 5'd0;
      armed_q      <= 1'b0;
      buzz_q       <= 1'b0;
      disp_alarm_q <= 1'b0;
      blink_q      <= 3'b000;
    end else begin
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      scnt_q       <= scnt_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      sec_inc_q    <= sec_inc_d;
      min_inc_q    <= min_inc_d;
      hour_inc_q   <= hour_inc_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hour_q <= alarm_hour_d;
      armed_q      <= armed_d;
      buzz_q       <= buzz_d;
      disp_alarm_q <= disp_alarm_d;
      blink_q      <= blink_d;
    end
  end

  assign hms_if.o_sec_inc    = sec_inc_q;
  assign hms_if.o_min_inc    = min_inc_q;
  assign hms_if.o_hour_inc   = hour_inc_q;
  assign hms_if.o_mode       = mode_q;
  assign hms_if.o_position   = pos_q;
  assign hms_if.o_alarm_min  = alarm_min_q;
  assign hms_if.o_alarm_hour = alarm_hour_q;
  assign hms_if.o_armed      = armed_q;
  assign hms_if.o_buzz       = buzz_q;
  assign hms_if.o_disp_alarm = disp_alarm_q;
  assign hms_if.o_blink      = blink_q;

endmodule

// File: tb/tb_hms_clock_ctrl.sv
// tb/tb_hms_clock_ctrl.sv - scoreboard bench for hms_clock_ctrl
// Directed button/counter stimulus; expected inc pulses are queued and checked by a monitor.
module tb_hms_clock_ctrl;
  localparam int T1 = 10;
  localparam int TS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hms_clock_ctrl_if hms_if ();

  hms_clock_ctrl #(.TICK_1HZ(T1), .TICK_SAMPLE(TS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .hms_if (hms_if)
  );

  typedef struct {
    logic [2:0] incs;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   edge_n;
  bit   allow_ticks = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  // Monitor: every inc pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [2:0] got;
    exp_t e;
    got = {hms_if.o_hour_inc, hms_if.o_min_inc, hms_if.o_sec_inc};
    if (rst_n && got != 3'b000 && !(allow_ticks && got == 3'b001)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_inc", int'(got), 0);
      end else begin
        e = exp_q.pop_front();
        chk("inc_pattern", int'(got), int'(e.incs));
        if (e.at >= 0) chk("inc_cycle", edge_n, e.at);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] incs, input int at);
    exp_t e;
    e.incs = incs;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hms_if.i_sw0 = 1'b1;
    hms_if.i_sw1 = 1'b1;
    hms_if.i_sw2 = 1'b1;
    hms_if.i_sec = 6'd0;
    hms_if.i_min = 6'd0;
    hms_if.i_hour = 5'd0;
    allow_ticks = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic press_mask(input logic [2:0] mask, input int hold);
    hms_if.i_sw0 = ~mask[0];
    hms_if.i_sw1 = ~mask[1];
    hms_if.i_sw2 = ~mask[2];
    cyc(hold);
    hms_if.i_sw0 = 1'b1;
    hms_if.i_sw1 = 1'b1;
    hms_if.i_sw2 = 1'b1;
    cyc(6);
  endtask

  task automatic press(input int b);
    press_mask(3'(1 << b), 6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and free-running seconds tick.
    do_reset();
    chk("rst_mode", hms_if.o_mode, 0);
    chk("rst_position", hms_if.o_position, 0);
    chk("rst_incs", {hms_if.o_hour_inc, hms_if.o_min_inc, hms_if.o_sec_inc}, 0);
    chk("rst_alarm_min", hms_if.o_alarm_min, 0);
    chk("rst_alarm_hour", hms_if.o_alarm_hour, 0);
    chk("rst_armed", hms_if.o_armed, 0);
    chk("rst_buzz", hms_if.o_buzz, 0);
    chk("rst_disp_alarm", hms_if.o_disp_alarm, 0);
    chk("rst_blink", hms_if.o_blink, 0);
    push(3'b001, 10);
    push(3'b001, 20);
    push(3'b001, 30);
    cyc(35);
    drain("t1_leftover");

    // Full carry at 59:59.
    do_reset();
    hms_if.i_sec = 6'd59;
    hms_if.i_min = 6'd59;
    push(3'b111, 10);
    cyc(15);
    drain("t2_leftover");

    // Reset arriving while a sec pulse is high clears it at once.
    do_reset();
    cyc(10);
    chk("inflight_pulse", hms_if.o_sec_inc, 1);
    rst_n = 1'b0;
    #1;
    chk("inflight_cleared", hms_if.o_sec_inc, 0);

    // SETUP: select MIN, three manual increments, blink on bit1.
    do_reset();
    press(0);
    chk("t3_mode", hms_if.o_mode, 1);
    chk("t3_pos_sec", hms_if.o_position, 0);
    press(1);
    chk("t3_pos_min", hms_if.o_position, 1);
    repeat (3) push(3'b010, -1);
    repeat (3) press(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_blink", hms_if.o_blink, (((edge_n - 1) / 5) % 2 == 1) ? 3'b010 : 3'b000);
    end
    cyc(1);
    drain("t3_leftover");

    // ALARM: minute and hour wrap, no carry between them.
    do_reset();
    allow_ticks = 1'b1;
    press(0);
    press(0);
    chk("t4_mode", hms_if.o_mode, 2);
    chk("t4_pos", hms_if.o_position, 1);
    for (int i = 0; i < 61; i++) begin
      press(2);
      chk("t4_disp_alarm", hms_if.o_disp_alarm, 1);
    end
    chk("t4_alarm_min", hms_if.o_alarm_min, 1);
    chk("t4_alarm_hour0", hms_if.o_alarm_hour, 0);
    press(1);
    chk("t4_pos_hour", hms_if.o_position, 2);
    for (int i = 0; i < 23; i++) begin
      press(2);
      chk("t4_disp_alarm_h", hms_if.o_disp_alarm, 1);
    end
    chk("t4_alarm_hour23", hms_if.o_alarm_hour, 23);
    press(2);
    chk("t4_alarm_hour_wrap", hms_if.o_alarm_hour, 0);
    chk("t4_alarm_min_kept", hms_if.o_alarm_min, 1);
    drain("t4_leftover");

    // Arm, buzz on match, disarm.
    do_reset();
    allow_ticks = 1'b1;
    press(0);
    press(0);
    press(2);
    press(0);
    chk("t5_mode", hms_if.o_mode, 0);
    chk("t5_disp_alarm", hms_if.o_disp_alarm, 0);
    chk("t5_alarm_min", hms_if.o_alarm_min, 1);
    chk("t5_armed0", hms_if.o_armed, 0);
    press(2);
    chk("t5_armed1", hms_if.o_armed, 1);
    chk("t5_buzz_idle", hms_if.o_buzz, 0);
    hms_if.i_min = 6'd1;
    @(negedge clk);
    chk("t5_buzz_lag", hms_if.o_buzz, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_buzz_on", hms_if.o_buzz, 1);
    cyc(3);
    press(2);
    chk("t5_armed_off", hms_if.o_armed, 0);
    chk("t5_buzz_off", hms_if.o_buzz, 0);
    drain("t5_leftover");

    // Same-sample presses: priority and hold-once behaviour.
    do_reset();
    allow_ticks = 1'b1;
    press(0);
    press(0);
    press(0);
    chk("t6_clock_mode", hms_if.o_mode, 0);
    chk("t6_pos_kept", hms_if.o_position, 1);
    chk("t6_clock_blink", hms_if.o_blink, 0);
    press_mask(3'b011, 6);
    chk("t6_mode_setup", hms_if.o_mode, 1);
    chk("t6_pos_forced", hms_if.o_position, 0);
    allow_ticks = 1'b0;
    press_mask(3'b110, 6);
    chk("t6_pos_sw1_wins", hms_if.o_position, 1);
    push(3'b010, -1);
    press_mask(3'b100, 20);
    cyc(4);
    drain("t6_leftover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
